fifo_uart: RTL

- Parametrised successor to the single-byte UART.
- Configurable data width, optional parity, one or two stop bits.
- TX and RX FIFOs plus sticky error flags.
- Sits on the SoC register bus: CPU writes bytes into the TX FIFO and pops received bytes from the RX FIFO; ser_tx/ser_rx go to the pads.

---
 rtl/fifo_uart.sv | 363 ++++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/fifo_uart.sv
// fifo_uart: buffered UART for the SoC register bus.
//
// The CPU pushes bytes into a TX FIFO through reg_dat_we/reg_dat_di and pops
// received bytes from an RX FIFO through reg_dat_re/reg_dat_do. Frames carry
// DATA_BITS data bits (LSB first), an optional even/odd parity bit, and one or
// two stop bits on transmit. The receiver always checks exactly one stop bit.
// Framing, parity and overrun problems are recorded in sticky flags.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   ser_tx / ser_rx       pad-side serial lines (idle high; ser_rx is async)
//   reg_div_we/di/do      byte-writable bit-period divider (period = div+1)
//   cfg_parity_en/odd     parity present / odd parity select
//   cfg_stop2             two stop bits on transmit
//   reg_dat_we/di         push into TX FIFO (dropped while tx_full)
//   reg_dat_re/do         pop / view RX FIFO head (all ones when empty)
//   tx_full, tx_empty     TX FIFO full; TX FIFO empty and transmitter idle
//   rx_empty              RX FIFO empty
//   err_clr               clear sticky error flags
//   rx_overrun, rx_frame_err, rx_parity_err   sticky error flags
//
// Optional build macro FIFO_UART_LOOPBACK_EN adds input cfg_loopback, which
// routes the internal TX bit into the RX synchroniser and holds ser_tx high.

module fifo_uart #(
    parameter int          DATA_BITS = 8,
    parameter int          TX_DEPTH  = 16,
    parameter int          RX_DEPTH  = 16,
    parameter logic [31:0] DIV_RESET = 32'd104
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ser_tx,
    input  logic        ser_rx,
`ifdef FIFO_UART_LOOPBACK_EN
    input  logic        cfg_loopback,
`endif
    input  logic [3:0]  reg_div_we,
    input  logic [31:0] reg_div_di,
    output logic [31:0] reg_div_do,
    input  logic        cfg_parity_en,
    input  logic        cfg_parity_odd,
    input  logic        cfg_stop2,
    input  logic        reg_dat_we,
    input  logic        reg_dat_re,
    input  logic [31:0] reg_dat_di,
    output logic [31:0] reg_dat_do,
    output logic        tx_full,
    output logic        tx_empty,
    output logic        rx_empty,
    input  logic        err_clr,
    output logic        rx_overrun,
    output logic        rx_frame_err,
    output logic        rx_parity_err
);

    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP1, TX_STOP2
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
    } rx_state_t;

    // ------------------------------------------------------------------
    // Divider register
    // ------------------------------------------------------------------
    logic [31:0] cfg_divider;

    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_divider <= DIV_RESET;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (reg_div_we[i]) begin
                    cfg_divider[8*i +: 8] <= reg_div_di[8*i +: 8];
                end
            end
        end
    end

    assign reg_div_do = cfg_divider;

    // Upper write-data bits beyond the frame width are ignored by design.
    logic unused_di_bits;
    assign unused_di_bits = ^reg_dat_di[31:DATA_BITS];

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] tx_mem [TX_DEPTH];
    logic [TX_AW:0]       tx_wr_ptr, tx_rd_ptr;
    logic                 tx_fifo_empty, tx_push, tx_pop;
    logic [DATA_BITS-1:0] tx_head;

    assign tx_fifo_empty = (tx_wr_ptr == tx_rd_ptr);
    assign tx_full       = (tx_wr_ptr[TX_AW] != tx_rd_ptr[TX_AW]) &&
                           (tx_wr_ptr[TX_AW-1:0] == tx_rd_ptr[TX_AW-1:0]);
    assign tx_push       = reg_dat_we && !tx_full;
    assign tx_head       = tx_mem[tx_rd_ptr[TX_AW-1:0]];

    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem[tx_wr_ptr[TX_AW-1:0]] <= reg_dat_di[DATA_BITS-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // TX FSM
    // ------------------------------------------------------------------
    tx_state_t            tx_state;
    logic [31:0]          tx_cnt;
    logic [3:0]           tx_idx;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_bit, tx_par_q, tx_pen_q, tx_stop2_q;
    logic                 tx_bit_end, tx_frame_end;

    assign tx_bit_end   = (tx_cnt == cfg_divider);
    assign tx_frame_end = tx_bit_end &&
                          ((tx_state == TX_STOP1 && !tx_stop2_q) || tx_state == TX_STOP2);
    // Popping at the last stop-bit boundary makes consecutive frames abut.
    assign tx_pop       = !tx_fifo_empty && (tx_state == TX_IDLE || tx_frame_end);
    assign tx_empty     = tx_fifo_empty && (tx_state == TX_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state   <= TX_IDLE;
            tx_cnt     <= '0;
            tx_idx     <= '0;
            tx_shift   <= '0;
            tx_bit     <= 1'b1;
            tx_par_q   <= 1'b0;
            tx_pen_q   <= 1'b0;
            tx_stop2_q <= 1'b0;
        end else if (tx_pop) begin
            tx_state   <= TX_START;
            tx_cnt     <= '0;
            tx_shift   <= tx_head;
            tx_bit     <= 1'b0;
            tx_par_q   <= (^tx_head) ^ cfg_parity_odd;
            tx_pen_q   <= cfg_parity_en;
            tx_stop2_q <= cfg_stop2;
        end else if (tx_state == TX_IDLE) begin
            tx_bit <= 1'b1;
        end else if (!tx_bit_end) begin
            tx_cnt <= tx_cnt + 32'd1;
        end else begin
            tx_cnt <= '0;
            case (tx_state)
                TX_START: begin
                    tx_state <= TX_DATA;
                    tx_idx   <= '0;
                    tx_bit   <= tx_shift[0];
                end
                TX_DATA: begin
                    if (tx_idx == LAST_BIT) begin
                        tx_state <= tx_pen_q ? TX_PARITY : TX_STOP1;
                        tx_bit   <= tx_pen_q ? tx_par_q : 1'b1;
                    end else begin
                        tx_idx   <= tx_idx + 4'd1;
                        tx_shift <= tx_shift >> 1;
                        tx_bit   <= tx_shift[1];
                    end
                end
                TX_PARITY: begin
                    tx_state <= TX_STOP1;
                    tx_bit   <= 1'b1;
                end
                TX_STOP1: begin
                    tx_state <= tx_stop2_q ? TX_STOP2 : TX_IDLE;
                    tx_bit   <= 1'b1;
                end
                default: begin
                    tx_state <= TX_IDLE;
                    tx_bit   <= 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Line routing (loopback option)
    // ------------------------------------------------------------------
    logic rx_line;

`ifdef FIFO_UART_LOOPBACK_EN
    assign rx_line = cfg_loopback ? tx_bit : ser_rx;
    assign ser_tx  = cfg_loopback ? 1'b1 : tx_bit;
`else
    assign rx_line = ser_rx;
    assign ser_tx  = tx_bit;
`endif

    // ------------------------------------------------------------------
    // RX synchroniser plus one delayed copy for falling-edge detection
    // ------------------------------------------------------------------
    logic rx_s1, rx_s2, rx_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx_line;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // ------------------------------------------------------------------
    // RX FSM
    // ------------------------------------------------------------------
    rx_state_t            rx_state;
    logic [31:0]          rx_cnt;
    logic [3:0]           rx_idx;
    logic [DATA_BITS-1:0] rx_shift, rx_push_data;
    logic                 rx_par_bit, rx_pen_q, rx_odd_q;
    logic                 rx_push_q, rx_ferr_set, rx_perr_set;
    logic                 rx_bit_end, rx_mid;

    assign rx_bit_end = (rx_cnt == cfg_divider);
    assign rx_mid     = (rx_cnt == (cfg_divider >> 1));

    // The frame ends at the stop-bit mid-sample so the idle state is already
    // watching the line when the next start edge arrives.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state     <= RX_IDLE;
            rx_cnt       <= '0;
            rx_idx       <= '0;
            rx_shift     <= '0;
            rx_par_bit   <= 1'b0;
            rx_pen_q     <= 1'b0;
            rx_odd_q     <= 1'b0;
            rx_push_q    <= 1'b0;
            rx_push_data <= '0;
            rx_ferr_set  <= 1'b0;
            rx_perr_set  <= 1'b0;
        end else begin
            rx_push_q   <= 1'b0;
            rx_ferr_set <= 1'b0;
            rx_perr_set <= 1'b0;
            if (rx_state == RX_IDLE) begin
                if (rx_prev && !rx_s2) begin
                    rx_state <= RX_START;
                    rx_cnt   <= '0;
                    rx_pen_q <= cfg_parity_en;
                    rx_odd_q <= cfg_parity_odd;
                end
            end else begin
                rx_cnt <= rx_bit_end ? 32'd0 : rx_cnt + 32'd1;
                case (rx_state)
                    RX_START: begin
                        if (rx_mid && rx_s2) begin
                            rx_state <= RX_IDLE;
                        end else if (rx_bit_end) begin
                            rx_state <= RX_DATA;
                            rx_idx   <= '0;
                        end
                    end
                    RX_DATA: begin
                        if (rx_mid) begin
                            rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
                        end
                        if (rx_bit_end) begin
                            if (rx_idx == LAST_BIT) begin
                                rx_state <= rx_pen_q ? RX_PARITY : RX_STOP;
                            end else begin
                                rx_idx <= rx_idx + 4'd1;
                            end
                        end
                    end
                    RX_PARITY: begin
                        if (rx_mid) begin
                            rx_par_bit <= rx_s2;
                        end else if (rx_bit_end) begin
                            rx_state <= RX_STOP;
                        end
                    end
                    RX_STOP: begin
                        if (rx_mid) begin
                            rx_state <= RX_IDLE;
                            if (!rx_s2) begin
                                rx_ferr_set <= 1'b1;
                            end else begin
                                rx_push_q    <= 1'b1;
                                rx_push_data <= rx_shift;
                                rx_perr_set  <= rx_pen_q &&
                                                (((^rx_shift) ^ rx_odd_q) != rx_par_bit);
                            end
                        end
                    end
                    default: rx_state <= RX_IDLE;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // RX FIFO
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] rx_mem [RX_DEPTH];
    logic [RX_AW:0]       rx_wr_ptr, rx_rd_ptr;
    logic                 rx_full, rx_pop, rx_push, rx_drop;

    assign rx_empty = (rx_wr_ptr == rx_rd_ptr);
    assign rx_full  = (rx_wr_ptr[RX_AW] != rx_rd_ptr[RX_AW]) &&
                      (rx_wr_ptr[RX_AW-1:0] == rx_rd_ptr[RX_AW-1:0]);
    assign rx_pop   = reg_dat_re && !rx_empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign rx_push  = rx_push_q && (!rx_full || rx_pop);
    assign rx_drop  = rx_push_q && rx_full && !rx_pop;

    assign reg_dat_do = rx_empty ? 32'hFFFF_FFFF
                      : {{(32-DATA_BITS){1'b0}}, rx_mem[rx_rd_ptr[RX_AW-1:0]]};

    always_ff @(posedge clk) begin
        if (rx_push) begin
            rx_mem[rx_wr_ptr[RX_AW-1:0]] <= rx_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
        end else begin
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Sticky error flags: a set event beats a simultaneous clear
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_overrun    <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_parity_err <= 1'b0;
        end else begin
            rx_overrun    <= rx_drop     | (rx_overrun    & ~err_clr);
            rx_frame_err  <= rx_ferr_set | (rx_frame_err  & ~err_clr);
            rx_parity_err <= rx_perr_set | (rx_parity_err & ~err_clr);
        end
    end

endmodule
